// File: rtl/risc_spm_pkg.sv
// risc_spm_pkg: shared state encoding, width defaults and port ids for the RISC SPM memory path
package risc_spm_pkg;
  localparam int WORD_SIZE_DEF = 8;
  localparam int ADDR_SIZE_DEF = 8;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_t;
endpackage

// File: rtl/rr_lock_pick.sv
// rr_lock_pick: round-robin winner select with a bounded loader lock
module rr_lock_pick import risc_spm_pkg::*; (
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       last,
  input  logic       lock1,
  input  logic       sat,
  output logic       valid,
  output logic       win,
  output logic       locked
);
  logic [1:0] elig;
  logic       hold;
  always_comb begin
    elig = req & ~mask;
    // while the loader holds the lock nobody else may start, even if the loader is masked
    hold = (last == PORT_LDR) & lock1 & req[1] & ~sat;
    valid = hold ? elig[1] : |elig;
    win = hold | (&elig ? ~last : elig[1]);
    locked = hold & elig[1];
  end
endmodule

// File: rtl/risc_mem_arbiter.sv
// risc_mem_arbiter: two-port req/ack arbiter in front of the RISC SPM single-port SRAM
module risc_mem_arbiter import risc_spm_pkg::*; #(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int LOCK_MAX  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [WORD_SIZE-1:0] wdata0,
  output logic                 ack0,
  output logic [WORD_SIZE-1:0] rdata0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [WORD_SIZE-1:0] wdata1,
  output logic                 ack1,
  output logic [WORD_SIZE-1:0] rdata1,
  input  logic                 lock1,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 mem_write,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 cpu_wait,
  output logic                 grant_id
);
  localparam int CW = $clog2(LOCK_MAX + 1);
  state_t               state_q, state_d;
  logic                 grant_q, grant_d, we_q, we_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           mask;
  logic                 valid, win, locked, take, rd_done;
  rr_lock_pick u_pick (
    .req    ({req1, req0}),
    .mask   (mask),
    .last   (grant_q),
    .lock1  (lock1),
    .sat    (cnt_q >= CW'(LOCK_MAX)),
    .valid  (valid),
    .win    (win),
    .locked (locked)
  );
  always_comb begin
    // the port just acked still holds req during RESP, so keep it out of that decision
    mask = (state_q == ST_RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    take = (state_q != ST_ACCESS) & valid;
    state_d = take ? ST_ACCESS : (state_q == ST_ACCESS ? ST_RESP : ST_IDLE);
    grant_d = take ? win : grant_q;
    addr_d = take ? (win ? addr1 : addr0) : addr_q;
    wdata_d = take ? (win ? wdata1 : wdata0) : wdata_q;
    we_d = take ? (win ? we1 : we0) : we_q;
    rd_done = (state_q == ST_ACCESS) & ~we_q;
    rdata0_d = (rd_done & (grant_q == PORT_CPU)) ? mem_rdata : rdata0_q;
    rdata1_d = (rd_done & (grant_q == PORT_LDR)) ? mem_rdata : rdata1_q;
    cnt_d = (!lock1 || (take && win == PORT_CPU)) ? '0 :
            (take && locked && req0) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= PORT_LDR;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      cnt_q    <= cnt_d;
    end
  end
  assign mem_write = (state_q == ST_ACCESS) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ack0      = (state_q == ST_RESP) & (grant_q == PORT_CPU);
  assign ack1      = (state_q == ST_RESP) & (grant_q == PORT_LDR);
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign cpu_wait  = req0 & ~ack0;
  assign grant_id  = grant_q;
endmodule

// File: tb/tb_risc_mem_arbiter.sv
// tb_risc_mem_arbiter: scoreboard bench with a cycle-numbered transaction model of the arbiter
module tb_risc_mem_arbiter;
  localparam int LM = 4;
  logic clk = 0, rst = 0;
  logic req0 = 0, we0 = 0, req1 = 0, we1 = 0, lock1 = 0;
  logic [7:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
  logic ack0, ack1, mem_write, cpu_wait, grant_id;
  logic [7:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic [7:0] sram [256];
  logic [7:0] ref_mem [256];
  int vec = 0, fail = 0;
  typedef struct {int cyc; logic we; logic [7:0] addr; logic [7:0] data;} exp_t;
  exp_t eq0[$], eq1[$], mq[$];
  int cyc = 0, free_at = 0, resp_at = -1, served = 0, m_cnt = 0, m_win;
  logic m_last = 1'b1;
  bit m_e0, m_e1, m_hold, rand_done = 0;
  risc_mem_arbiter #(.WORD_SIZE(8), .ADDR_SIZE(8), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .lock1(lock1), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .cpu_wait(cpu_wait), .grant_id(grant_id)
  );
  always #5 clk = ~clk;
  assign mem_rdata = sram[mem_addr];
  always @(posedge clk) if (mem_write) sram[mem_addr] <= mem_wdata;
  // Reference: a grant at edge c means the write shows during cycle c and the ack during cycle c+1;
  // the next decision is at edge c+2, where the served port is excluded.
  task automatic model_grant(input int p);
    exp_t e;
    e.cyc = cyc + 1;
    e.we = p ? we1 : we0;
    e.addr = p ? addr1 : addr0;
    e.data = e.we ? (p ? wdata1 : wdata0) : ref_mem[e.addr];
    if (p) eq1.push_back(e); else eq0.push_back(e);
    if (e.we) begin
      ref_mem[e.addr] = e.data;
      mq.push_back('{cyc, 1'b1, e.addr, e.data});
    end
    free_at = cyc + 2;
    resp_at = cyc + 2;
    served = p;
    m_last = p[0];
  endtask
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      eq0.delete(); eq1.delete(); mq.delete();
      m_last = 1'b1; m_cnt = 0; free_at = 0; resp_at = -1;
    end else begin
      cyc++;
      m_win = -1;
      m_hold = 0;
      if (cyc >= free_at) begin
        m_e0 = req0 && !(cyc == resp_at && served == 0);
        m_e1 = req1 && !(cyc == resp_at && served == 1);
        m_hold = m_last && lock1 && req1 && m_cnt < LM;
        if (m_hold) m_win = m_e1 ? 1 : -1;
        else if (m_e0 && m_e1) m_win = m_last ? 0 : 1;
        else m_win = m_e1 ? 1 : (m_e0 ? 0 : -1);
      end
      if (!lock1 || m_win == 0) m_cnt = 0;
      else if (m_win == 1 && m_hold && req0) m_cnt++;
      if (m_win >= 0) model_grant(m_win);
    end
  end
  task automatic check_port(input int p, input logic ack, input logic [7:0] rd);
    exp_t e;
    int n;
    n = p ? eq1.size() : eq0.size();
    while (n > 0) begin
      e = p ? eq1[0] : eq0[0];
      if (e.cyc >= cyc) break;
      vec++; fail++;
      $display("FAIL missing_ack%0d: no ack seen, required at cycle %0d", p, e.cyc);
      if (p) void'(eq1.pop_front()); else void'(eq0.pop_front());
      n--;
    end
    if (ack) begin
      vec++;
      if (n == 0) begin
        fail++;
        $display("FAIL unexpected_ack%0d: ack at cycle %0d, required none", p, cyc);
      end else begin
        if (p) e = eq1.pop_front(); else e = eq0.pop_front();
        if (e.cyc != cyc || (!e.we && rd !== e.data)) begin
          fail++;
          $display("FAIL ack%0d: cycle %0d rdata %h, required cycle %0d rdata %h (we=%0b)",
                   p, cyc, rd, e.cyc, e.data, e.we);
        end
      end
    end
  endtask
  task automatic check_mem();
    exp_t e;
    while (mq.size() > 0 && mq[0].cyc < cyc) begin
      vec++; fail++;
      $display("FAIL missing_write: no write observed, required at cycle %0d", mq[0].cyc);
      void'(mq.pop_front());
    end
    if (mem_write) begin
      vec++;
      if (mq.size() == 0) begin
        fail++;
        $display("FAIL unexpected_write: addr %h data %h at cycle %0d, required none", mem_addr, mem_wdata, cyc);
      end else begin
        e = mq.pop_front();
        if (e.cyc != cyc || mem_addr !== e.addr || mem_wdata !== e.data) begin
          fail++;
          $display("FAIL write: cycle %0d addr %h data %h, required cycle %0d addr %h data %h",
                   cyc, mem_addr, mem_wdata, e.cyc, e.addr, e.data);
        end
      end
    end
  endtask
  always @(negedge clk) if (rst) begin
    vec++;
    if (grant_id !== m_last) begin
      fail++;
      $display("FAIL grant_id: got %b, required %b at cycle %0d", grant_id, m_last, cyc);
    end
    vec++;
    if (cpu_wait !== (req0 & ~ack0)) begin
      fail++;
      $display("FAIL cpu_wait: got %b, required %b at cycle %0d", cpu_wait, req0 & ~ack0, cyc);
    end
    check_port(0, ack0, rdata0);
    check_port(1, ack1, rdata1);
    check_mem();
  end
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vec++;
    if (act !== exp) begin
      fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask
  task automatic issue(input int p, input logic we, input logic [7:0] a, input logic [7:0] d);
    if (p) begin we1 = we; addr1 = a; wdata1 = d; req1 = 1; end
    else begin we0 = we; addr0 = a; wdata0 = d; req0 = 1; end
  endtask
  task automatic finish_txn(input int p, input bit drop_early);
    int k = 0;
    bit got = 0;
    while (!got) begin
      step(1);
      got = p ? ack1 : ack0;
      k++;
      if (!got && drop_early && k == 1) begin
        if (p) req1 = 0; else req0 = 0;
        step(3);
        return;
      end
      if (!got && k > 100) begin
        vec++; fail++;
        $display("FAIL ack_timeout%0d: no ack after %0d cycles, required ack", p, k);
        break;
      end
    end
    if (p) req1 = 0; else req0 = 0;
  endtask
  task automatic txn(input int p, input logic we, input logic [7:0] a, input logic [7:0] d);
    issue(p, we, a, d);
    finish_txn(p, 0);
  endtask
  task automatic run_port(input int p, input int n, input int maxgap, input int droppct);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(maxgap, 0));
      issue(p, 1'($urandom_range(1, 0)), {4'h0, 4'($urandom_range(15, 0))}, 8'($urandom));
      finish_txn(p, $urandom_range(99, 0) < droppct);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i] = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    issue(0, 0, 8'h12, 8'h00);
    repeat (3) @(negedge clk);
    chk("rst_ack0", 8'(ack0), 8'h00);
    chk("rst_ack1", 8'(ack1), 8'h00);
    chk("rst_mem_write", 8'(mem_write), 8'h00);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_rdata0", rdata0, 8'h00);
    chk("rst_rdata1", rdata1, 8'h00);
    chk("rst_grant_id", 8'(grant_id), 8'h01);
    #1 rst = 1;
    finish_txn(0, 0);
    txn(0, 1, 8'h12, 8'hA5);
    txn(0, 0, 8'h12, 8'h00);
    chk("rd_after_wr", rdata0, 8'hA5);
    lock1 = 0;
    fork
      run_port(0, 6, 0, 0);
      run_port(1, 6, 0, 0);
    join
    step(2);
    lock1 = 1;
    fork
      run_port(0, 10, 0, 0);
      run_port(1, 20, 0, 0);
    join
    lock1 = 0;
    step(3);
    issue(1, 1, 8'h30, 8'h3C);
    @(posedge clk); #1;
    req1 = 0;
    issue(0, 0, 8'h44, 8'h00);
    @(posedge clk); #1;
    chk("ack1_after_drop", 8'(ack1), 8'h01);
    req0 = 0;
    step(3);
    txn(0, 0, 8'h30, 8'h00);
    chk("dropped_write_landed", rdata0, 8'h3C);
    step(2);
    issue(0, 0, 8'h12, 8'h00);
    @(posedge clk); #2;
    rst = 0;
    req0 = 0;
    step(1);
    chk("midrst_ack0", 8'(ack0), 8'h00);
    chk("midrst_rdata0", rdata0, 8'h00);
    chk("midrst_grant_id", 8'(grant_id), 8'h01);
    rst = 1;
    step(3);
    fork
      begin
        fork
          run_port(0, 60, 3, 10);
          run_port(1, 60, 3, 10);
        join
        rand_done = 1;
      end
      while (!rand_done) begin
        lock1 = ($urandom_range(3, 0) != 0);
        step($urandom_range(12, 1));
      end
    join
    lock1 = 0;
    step(6);
    vec++;
    if (eq0.size() + eq1.size() + mq.size() != 0) begin
      fail++;
      $display("FAIL drain: %0d expected events outstanding, required 0", eq0.size() + eq1.size() + mq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, fail);
    $finish;
  end
endmodule
